// File: rtl/bus_timer_if.sv
// Follower-side bus bundle for one system_bus slot: request fields in, single-cycle read response out.
interface bus_timer_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        read_req;
  logic        write_req;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    output addr, write_data, byte_enable, read_req, write_req,
    input  read_data, read_data_valid
  );

  modport slave (
    input  addr, write_data, byte_enable, read_req, write_req,
    output read_data, read_data_valid
  );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer: prescaled mtime, mtimecmp, level irq,
// with a shadowed high word so software can read mtime atomically (LO then HI).
module bus_timer #(
  parameter int unsigned Tag = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  bus_timer_if.slave bus,
  output logic       irq
);

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_PRESCALE = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_e;

  localparam int unsigned tag_unused = Tag;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] pre_cnt;
  logic [15:0] prescale;
  logic [31:0] shadow;
  logic        ctrl_en;
  logic        ctrl_irq_en;

  reg_e        sel;
  logic        wr_en;
  logic        tick;
  logic        expired;
  logic [31:0] cur_word;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic        addr_unused;

  assign sel         = reg_e'(bus.addr[4:2]);
  assign addr_unused = ^{bus.addr[31:5], bus.addr[1:0]};
  assign wr_en       = bus.write_req && (bus.byte_enable != '0);
  assign tick        = ctrl_en && (pre_cnt == prescale);
  assign expired     = (mtime >= mtimecmp);

  // cur_word is the live register (merge base for writes); reads of
  // MTIME_HI differ only in returning the shadow instead.
  always_comb begin
    cur_word = '0;
    case (sel)
      REG_MTIME_LO: cur_word = mtime[31:0];
      REG_MTIME_HI: cur_word = mtime[63:32];
      REG_CMP_LO:   cur_word = mtimecmp[31:0];
      REG_CMP_HI:   cur_word = mtimecmp[63:32];
      REG_CTRL:     cur_word = {30'd0, ctrl_irq_en, ctrl_en};
      REG_PRESCALE: cur_word = {16'd0, prescale};
      REG_STATUS:   cur_word = {31'd0, expired};
      default:      cur_word = '0;
    endcase
    rd_word = (sel == REG_MTIME_HI) ? shadow : cur_word;
    wr_word = cur_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (bus.byte_enable[k]) wr_word[8*k +: 8] = bus.write_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime               <= '0;
      mtimecmp            <= '1;
      pre_cnt             <= '0;
      prescale            <= '0;
      shadow              <= '0;
      ctrl_en             <= 1'b0;
      ctrl_irq_en         <= 1'b0;
      irq                 <= 1'b0;
      bus.read_data       <= '0;
      bus.read_data_valid <= 1'b0;
    end else begin
      // A software write to either mtime half wins over the prescaler tick.
      if (wr_en && sel == REG_MTIME_LO)      mtime[31:0]  <= wr_word;
      else if (wr_en && sel == REG_MTIME_HI) mtime[63:32] <= wr_word;
      else if (tick)                         mtime        <= mtime + 64'd1;

      if (wr_en && sel == REG_PRESCALE) pre_cnt <= '0;
      else if (tick)                    pre_cnt <= '0;
      else if (ctrl_en)                 pre_cnt <= pre_cnt + 16'd1;

      if (wr_en && sel == REG_CMP_LO) mtimecmp[31:0]  <= wr_word;
      if (wr_en && sel == REG_CMP_HI) mtimecmp[63:32] <= wr_word;
      if (wr_en && sel == REG_CTRL) begin
        ctrl_en     <= wr_word[0];
        ctrl_irq_en <= wr_word[1];
      end
      if (wr_en && sel == REG_PRESCALE) prescale <= wr_word[15:0];

      if (bus.read_req && sel == REG_MTIME_LO) shadow <= mtime[63:32];

      bus.read_data_valid <= bus.read_req;
      bus.read_data       <= bus.read_req ? rd_word : '0;
      irq                 <= ctrl_irq_en && expired;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus random bus traffic
// checked against a closed-form model of mtime (elapsed enabled cycles / (PRESCALE+1)).
module tb_bus_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  bus_timer_if bus();

  bus_timer #(.Tag(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Model: state known exactly at anchor edge m_a; later values derived arithmetically.
  longint unsigned m_a;
  logic [63:0]     m_base;
  int unsigned     m_pre;
  int unsigned     m_ps;
  bit              m_en;
  bit              m_ie;
  logic [63:0]     m_cmp;
  logic [31:0]     m_shadow;

  function automatic logic [63:0] mt_at(longint unsigned k);
    if (!m_en || k <= m_a) return m_base;
    return m_base + 64'((longint'(m_pre) + (k - m_a)) / (longint'(m_ps) + 1));
  endfunction

  function automatic int unsigned pre_at(longint unsigned k);
    if (!m_en || k <= m_a) return m_pre;
    return 32'((longint'(m_pre) + (k - m_a)) % (longint'(m_ps) + 1));
  endfunction

  function automatic void model_reset();
    m_a = cyc; m_base = '0; m_pre = 0; m_ps = 0;
    m_en = 1'b0; m_ie = 1'b0; m_cmp = '1; m_shadow = '0;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = d[8*k +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_read(logic [2:0] r, longint unsigned e);
    logic [63:0] mt;
    mt = mt_at(e - 1);
    case (r)
      3'd0: return mt[31:0];
      3'd1: return m_shadow;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_ie, m_en};
      3'd5: return m_ps;
      3'd6: return {31'd0, mt >= m_cmp};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(logic [2:0] r, logic [31:0] d, logic [3:0] be, longint unsigned e);
    logic [63:0] mt;
    logic [31:0] w;
    int unsigned p;
    if (be == 4'd0) return;
    case (r)
      3'd0, 3'd1: begin
        mt = mt_at(e - 1);
        p  = pre_at(e);
        if (r == 3'd0) mt[31:0] = merge(mt[31:0], d, be);
        else           mt[63:32] = merge(mt[63:32], d, be);
        m_a = e; m_base = mt; m_pre = p;
      end
      3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], d, be);
      3'd3: m_cmp[63:32] = merge(m_cmp[63:32], d, be);
      3'd4: begin
        w = merge({30'd0, m_ie, m_en}, d, be);
        mt = mt_at(e); p = pre_at(e);
        m_a = e; m_base = mt; m_pre = p;
        m_en = w[0]; m_ie = w[1];
      end
      3'd5: begin
        w = merge(m_ps, d, be);
        mt = mt_at(e);
        m_a = e; m_base = mt; m_pre = 0;
        m_ps = {16'd0, w[15:0]};
      end
      default: ;
    endcase
  endfunction

  // One bus transaction: drive on a falling edge, check response/irq on the next.
  task automatic op(input bit rd, input bit wr, input logic [31:0] addr,
                    input logic [31:0] d, input logic [3:0] be, input string name);
    logic [2:0]      r;
    longint unsigned e;
    logic [31:0]     exp_d;
    logic [63:0]     mt;
    bit              exp_irq;
    r = addr[4:2];
    @(negedge clk);
    bus.addr = addr; bus.write_data = d; bus.byte_enable = be;
    bus.read_req = rd; bus.write_req = wr;
    e = cyc + 1;
    mt = mt_at(e - 1);
    exp_d = rd ? model_read(r, e) : 32'd0;
    exp_irq = m_ie && (mt >= m_cmp);
    if (rd && r == 3'd0) m_shadow = mt[63:32];
    if (wr) model_write(r, d, be, e);
    @(negedge clk);
    bus.read_req = 1'b0; bus.write_req = 1'b0;
    tests++;
    if (bus.read_data_valid !== rd) begin
      fails++; $display("FAIL %s valid: got %b expected %b", name, bus.read_data_valid, rd);
    end
    tests++;
    if (bus.read_data !== exp_d) begin
      fails++; $display("FAIL %s data: got %h expected %h", name, bus.read_data, exp_d);
    end
    tests++;
    if (irq !== exp_irq) begin
      fails++; $display("FAIL %s irq: got %b expected %b", name, irq, exp_irq);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.read_req = 1'b0; bus.write_req = 1'b0;
    bus.addr = '0; bus.write_data = '0; bus.byte_enable = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (irq !== 1'b0 || bus.read_data_valid !== 1'b0 || bus.read_data !== 32'd0) begin
      fails++; $display("FAIL reset_outputs: got irq=%b valid=%b data=%h expected 0/0/0",
                        irq, bus.read_data_valid, bus.read_data);
    end
    op(1'b1, 1'b0, 32'h0C, 32'd0, 4'h0, "reset_cmp_hi");
    @(negedge clk);
    tests++;
    if (bus.read_data_valid !== 1'b0 || bus.read_data !== 32'd0) begin
      fails++; $display("FAIL reset_pulse_width: got valid=%b data=%h expected 0/0",
                        bus.read_data_valid, bus.read_data);
    end
  endtask

  task automatic test_prescale();
    do_reset();
    op(1'b0, 1'b1, 32'h14, 32'd3, 4'hF, "ps_wr_prescale");
    op(1'b0, 1'b1, 32'h10, 32'd1, 4'hF, "ps_wr_ctrl");
    repeat (40) @(negedge clk);
    op(1'b1, 1'b0, 32'h00, 32'd0, 4'h0, "ps_read_lo");
    op(1'b1, 1'b0, 32'h14, 32'd0, 4'h0, "ps_read_prescale");
  endtask

  task automatic test_atomic();
    do_reset();
    op(1'b0, 1'b1, 32'h04, 32'd0, 4'hF, "at_wr_hi");
    op(1'b0, 1'b1, 32'h00, 32'hFFFF_FFFE, 4'hF, "at_wr_lo");
    op(1'b0, 1'b1, 32'h14, 32'd0, 4'hF, "at_wr_ps");
    op(1'b0, 1'b1, 32'h10, 32'd1, 4'hF, "at_wr_ctrl");
    op(1'b1, 1'b0, 32'h00, 32'd0, 4'h0, "at_read_lo");
    op(1'b1, 1'b0, 32'h04, 32'd0, 4'h0, "at_read_hi_shadow");
    op(1'b1, 1'b0, 32'h00, 32'd0, 4'h0, "at_reread_lo");
    op(1'b1, 1'b0, 32'h04, 32'd0, 4'h0, "at_reread_hi");
  endtask

  task automatic test_byte_enable();
    do_reset();
    op(1'b0, 1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, "be_wr_cmp_lo");
    op(1'b1, 1'b0, 32'h08, 32'd0, 4'h0, "be_read_cmp_lo");
    op(1'b0, 1'b1, 32'h08, 32'h1234_5678, 4'b0000, "be_zero_write");
    op(1'b1, 1'b0, 32'h1000_002B, 32'd0, 4'h0, "be_read_alias");
    op(1'b0, 1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, "be_wr_status");
    op(1'b0, 1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, "be_wr_rsvd");
    op(1'b1, 1'b0, 32'h1C, 32'd0, 4'h0, "be_read_rsvd");
    op(1'b1, 1'b0, 32'h18, 32'd0, 4'h0, "be_read_status");
  endtask

  task automatic test_irq();
    bit          exp_irq;
    bit          seen;
    logic [63:0] mt;
    do_reset();
    op(1'b0, 1'b1, 32'h0C, 32'd0, 4'hF, "irq_wr_cmp_hi");
    op(1'b0, 1'b1, 32'h08, 32'd5, 4'hF, "irq_wr_cmp_lo");
    op(1'b0, 1'b1, 32'h10, 32'd3, 4'hF, "irq_wr_ctrl");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mt = mt_at(cyc - 1);
      exp_irq = m_ie && (mt >= m_cmp);
      seen |= exp_irq;
      tests++;
      if (irq !== exp_irq) begin
        fails++; $display("FAIL irq_rise cycle %0d: got %b expected %b", i, irq, exp_irq);
      end
    end
    tests++;
    if (!seen || irq !== 1'b1) begin
      fails++; $display("FAIL irq_asserted: got %b expected 1", irq);
    end
    op(1'b0, 1'b1, 32'h0C, 32'd1, 4'hF, "irq_raise_cmp");
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_fall: got %b expected 0", irq);
    end
    op(1'b0, 1'b1, 32'h0C, 32'd0, 4'hF, "irq_lower_cmp");
    op(1'b0, 1'b1, 32'h10, 32'd1, 4'h1, "irq_clear_en");
    op(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, "irq_after_clear");
  endtask

  task automatic test_concurrency();
    do_reset();
    op(1'b0, 1'b1, 32'h10, 32'd1, 4'hF, "cc_wr_ctrl");
    repeat (5) @(negedge clk);
    op(1'b1, 1'b1, 32'h00, 32'h1234_5678, 4'hF, "cc_rw_lo");
    op(1'b1, 1'b0, 32'h00, 32'd0, 4'h0, "cc_read_after");
    op(1'b1, 1'b1, 32'h14, 32'd7, 4'h1, "cc_rw_prescale");
    op(1'b1, 1'b0, 32'h14, 32'd0, 4'h0, "cc_read_prescale");
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk);
    bus.addr = 32'h0C; bus.read_req = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.read_data_valid !== 1'b0 || bus.read_data !== 32'd0 || irq !== 1'b0) begin
      fails++; $display("FAIL rst_mid_immediate: got valid=%b data=%h irq=%b expected 0/0/0",
                        bus.read_data_valid, bus.read_data, irq);
    end
    @(negedge clk);
    bus.read_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.read_data_valid !== 1'b0) begin
        fails++; $display("FAIL rst_mid_no_valid %0d: got %b expected 0", i, bus.read_data_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]      r;
    longint unsigned e;
    logic [31:0]     exp_d;
    logic [63:0]     mt;
    do_reset();
    op(1'b0, 1'b1, 32'h14, 32'($urandom_range(0, 2)), 4'hF, "b2b_wr_ps");
    op(1'b0, 1'b1, 32'h10, 32'd1, 4'hF, "b2b_wr_ctrl");
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      r = (i < 2) ? 3'(i) : 3'($urandom_range(0, 7));
      bus.addr = {27'($urandom), r, 2'($urandom)};
      bus.read_req = 1'b1;
      e = cyc + 1;
      mt = mt_at(e - 1);
      exp_d = model_read(r, e);
      if (r == 3'd0) m_shadow = mt[63:32];
      @(negedge clk);
      tests++;
      if (bus.read_data_valid !== 1'b1 || bus.read_data !== exp_d) begin
        fails++; $display("FAIL b2b read %0d reg %0d: got valid=%b data=%h expected 1/%h",
                          i, r, bus.read_data_valid, bus.read_data, exp_d);
      end
    end
    bus.read_req = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.read_data_valid !== 1'b0 || bus.read_data !== 32'd0) begin
      fails++; $display("FAIL b2b_idle: got valid=%b data=%h expected 0/0",
                        bus.read_data_valid, bus.read_data);
    end
  endtask

  task automatic test_random();
    logic [2:0]  r;
    logic [31:0] d;
    bit          rd;
    bit          wr;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r  = 3'($urandom_range(0, 7));
      rd = 1'($urandom);
      wr = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      if (r == 3'd5) d = $urandom_range(0, 4);
      if (r == 3'd3 || r == 3'd1) d = $urandom_range(0, 1);
      op(rd, wr, {27'($urandom), r, 2'($urandom)}, d, 4'($urandom), "rand");
    end
  endtask

  initial begin
    bus.addr = '0; bus.write_data = '0; bus.byte_enable = '0;
    bus.read_req = 1'b0; bus.write_req = 1'b0;
    test_reset();
    test_prescale();
    test_atomic();
    test_byte_enable();
    test_irq();
    test_concurrency();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
